id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
ID/EX pipeline register of the 5-stage RV32I core. It latches decoded operands, register indices and control bits from ID, and drives the EX stage and the Forwarding_Unit inputs (ID_EX_RS1, ID_EX_RS2). It contains load-use hazard detection: it freezes PC and IF/ID and inserts a bubble. It also honours a branch flush and a global pipeline hold.

Parameters:
XLEN, 32, datapath width of PC, operands and immediate
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
Hold  in  1  global freeze from memory stall; all state held
Flush  in  1  branch/jump taken in EX; squash the instruction entering EX
IF_ID_RS1  in  5  rs1 index of instruction in ID
IF_ID_RS2  in  5  rs2 index of instruction in ID
IF_ID_Rd  in  5  rd index in ID
IF_ID_UsesRS1  in  1  instruction in ID reads rs1
IF_ID_UsesRS2  in  1  instruction in ID reads rs2
IF_ID_PC  in  XLEN  PC of instruction in ID
RS1_Data  in  XLEN  register file read port 1
RS2_Data  in  XLEN  register file read port 2
Imm  in  XLEN  sign-extended immediate
Funct  in  4  {funct7[5], funct3}
Ctrl_RegWrite, Ctrl_MemRead, Ctrl_MemWrite, Ctrl_MemtoReg, Ctrl_ALUSrc, Ctrl_Branch  in  1 each  decoder control
Ctrl_ALUOp  in  2  decoder ALU op class
ID_EX_PC, ID_EX_RS1_Data, ID_EX_RS2_Data, ID_EX_Imm  out  XLEN  registered copies
ID_EX_RS1, ID_EX_RS2, ID_EX_Rd  out  5  registered indices (to Forwarding_Unit / EX_MEM)
ID_EX_Funct  out  4  registered funct
ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Branch  out  1 each  registered control
ID_EX_ALUOp  out  2  registered control
ID_EX_Valid  out  1  1 = real instruction, 0 = bubble
PCWrite  out  1  combinational; 0 freezes PC
IF_ID_Write  out  1  combinational; 0 freezes IF/ID
Bubble_Count  out  CNT_W  hazard-bubble count, saturating

Behaviour:
- Reset (reset=0, async): all registered outputs are 0, including ID_EX_Valid=0 and Bubble_Count=0. The register then holds a bubble.
- LoadUse = ID_EX_Valid & ID_EX_MemRead & (ID_EX_Rd!=0) & ((IF_ID_UsesRS1 & IF_ID_RS1==ID_EX_Rd) | (IF_ID_UsesRS2 & IF_ID_RS2==ID_EX_Rd)).
- PCWrite = IF_ID_Write = ~Hold & ~(LoadUse & ~Flush).
- Per rising edge, highest priority first:
  1. Hold=1: every register keeps its value and Bubble_Count is unchanged. Flush is ignored, so the requester keeps Flush asserted until Hold drops.
  2. Flush=1: load a bubble.
  3. LoadUse=1: load a bubble and increment Bubble_Count, saturating at 2^CNT_W-1.
  4. Otherwise: load all ID inputs and set ID_EX_Valid=1.
- Bubble definition: ID_EX_Valid=0 and all Ctrl outputs 0. ID_EX_RS1, ID_EX_RS2 and ID_EX_Rd are 0, so the Forwarding_Unit sees x0 and never forwards. Data, PC, Imm and Funct are also 0.
- Latency: 1 cycle from ID inputs to ID_EX outputs.
- LoadUse stalls are exactly 1 cycle. After the bubble, ID_EX_MemRead=0, so LoadUse deasserts and the held IF/ID instruction loads the next cycle.
- Flush together with LoadUse: Flush wins, PCWrite stays 1, and the counter does not increment.
- A write to rd=x0 never triggers LoadUse.
- Reset asserted mid-stall: the register clears immediately. PCWrite/IF_ID_Write follow the cleared state, which gives 1 unless Hold=1.

Test Plan:
- Reset mid-operation with a valid lw in ID/EX -> all outputs 0 asynchronously and ID_EX_Valid=0; PCWrite=1 once Hold=0.
- lw x5 in ID/EX; add x6,x5,x7 in ID (UsesRS1=1) -> PCWrite=0 and IF_ID_Write=0 for 1 cycle. Next cycle: bubble (RS1=RS2=Rd=0, RegWrite=0), Bubble_Count=1. Following cycle: add loaded with ID_EX_RS1=5, Valid=1.
- lw x0 in ID/EX; ID reads x0 -> no stall, PCWrite=1, instruction loads normally.
- LoadUse and Flush in the same cycle -> bubble loaded, PCWrite=1, Bubble_Count unchanged.
- Hold=1 for 3 cycles with Flush=1 and valid contents (Rd=9) -> outputs unchanged, PCWrite=0. When Hold drops with Flush still 1 -> bubble on that edge.
- With CNT_W=2, force 5 consecutive load-use stalls -> Bubble_Count saturates at 3.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and global hold.
// Inserts a one-cycle bubble on load-use and counts inserted hazard bubbles (saturating).
module id_ex_stage_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Hold,
  input  logic             Flush,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic [4:0]       IF_ID_Rd,
  input  logic             IF_ID_UsesRS1,
  input  logic             IF_ID_UsesRS2,
  input  logic [XLEN-1:0]  IF_ID_PC,
  input  logic [XLEN-1:0]  RS1_Data,
  input  logic [XLEN-1:0]  RS2_Data,
  input  logic [XLEN-1:0]  Imm,
  input  logic [3:0]       Funct,
  input  logic             Ctrl_RegWrite,
  input  logic             Ctrl_MemRead,
  input  logic             Ctrl_MemWrite,
  input  logic             Ctrl_MemtoReg,
  input  logic             Ctrl_ALUSrc,
  input  logic             Ctrl_Branch,
  input  logic [1:0]       Ctrl_ALUOp,
  output logic [XLEN-1:0]  ID_EX_PC,
  output logic [XLEN-1:0]  ID_EX_RS1_Data,
  output logic [XLEN-1:0]  ID_EX_RS2_Data,
  output logic [XLEN-1:0]  ID_EX_Imm,
  output logic [4:0]       ID_EX_RS1,
  output logic [4:0]       ID_EX_RS2,
  output logic [4:0]       ID_EX_Rd,
  output logic [3:0]       ID_EX_Funct,
  output logic             ID_EX_RegWrite,
  output logic             ID_EX_MemRead,
  output logic             ID_EX_MemWrite,
  output logic             ID_EX_MemtoReg,
  output logic             ID_EX_ALUSrc,
  output logic             ID_EX_Branch,
  output logic [1:0]       ID_EX_ALUOp,
  output logic             ID_EX_Valid,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic [CNT_W-1:0] Bubble_Count
);

  logic [XLEN-1:0]  pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [3:0]       funct_q, funct_d;
  logic             reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic             alu_src_q, alu_src_d, branch_q, branch_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             load_use;

  // A load targeting x0 never produces a value worth waiting for.
  assign load_use = valid_q & mem_read_q & (rd_q != 5'd0) &
                    ((IF_ID_UsesRS1 & (IF_ID_RS1 == rd_q)) |
                     (IF_ID_UsesRS2 & (IF_ID_RS2 == rd_q)));

  assign PCWrite     = ~Hold & ~(load_use & ~Flush);
  assign IF_ID_Write = PCWrite;

  always_comb begin
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    funct_d      = funct_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_src_d    = alu_src_q;
    branch_d     = branch_q;
    alu_op_d     = alu_op_q;
    valid_d      = valid_q;
    bubble_cnt_d = bubble_cnt_q;

    if (!Hold) begin
      if (Flush || load_use) begin
        // Bubble: zero indices so forwarding sees x0 and never matches.
        pc_d         = '0;
        rs1_data_d   = '0;
        rs2_data_d   = '0;
        imm_d        = '0;
        rs1_d        = '0;
        rs2_d        = '0;
        rd_d         = '0;
        funct_d      = '0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_d    = 1'b0;
        branch_d     = 1'b0;
        alu_op_d     = '0;
        valid_d      = 1'b0;
        if (!Flush && (bubble_cnt_q != {CNT_W{1'b1}})) begin
          bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        pc_d         = IF_ID_PC;
        rs1_data_d   = RS1_Data;
        rs2_data_d   = RS2_Data;
        imm_d        = Imm;
        rs1_d        = IF_ID_RS1;
        rs2_d        = IF_ID_RS2;
        rd_d         = IF_ID_Rd;
        funct_d      = Funct;
        reg_write_d  = Ctrl_RegWrite;
        mem_read_d   = Ctrl_MemRead;
        mem_write_d  = Ctrl_MemWrite;
        mem_to_reg_d = Ctrl_MemtoReg;
        alu_src_d    = Ctrl_ALUSrc;
        branch_d     = Ctrl_Branch;
        alu_op_d     = Ctrl_ALUOp;
        valid_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct_q      <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      branch_q     <= 1'b0;
      alu_op_q     <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      funct_q      <= funct_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      branch_q     <= branch_d;
      alu_op_q     <= alu_op_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ID_EX_PC       = pc_q;
  assign ID_EX_RS1_Data = rs1_data_q;
  assign ID_EX_RS2_Data = rs2_data_q;
  assign ID_EX_Imm      = imm_q;
  assign ID_EX_RS1      = rs1_q;
  assign ID_EX_RS2      = rs2_q;
  assign ID_EX_Rd       = rd_q;
  assign ID_EX_Funct    = funct_q;
  assign ID_EX_RegWrite = reg_write_q;
  assign ID_EX_MemRead  = mem_read_q;
  assign ID_EX_MemWrite = mem_write_q;
  assign ID_EX_MemtoReg = mem_to_reg_q;
  assign ID_EX_ALUSrc   = alu_src_q;
  assign ID_EX_Branch   = branch_q;
  assign ID_EX_ALUOp    = alu_op_q;
  assign ID_EX_Valid    = valid_q;
  assign Bubble_Count   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: driver predicts each edge's result from a
// behavioural pipeline model; an independent monitor compares after every rising edge.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        hold, flush;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [31:0] pc, d1, d2, imm;
    logic [3:0]  funct;
    logic        rw, mr, mw, m2r, as, br;
    logic [1:0]  aluop;
  } in_t;

  typedef struct packed {
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  funct;
    logic        rw, mr, mw, m2r, as, br;
    logic [1:0]  aluop;
    logic        valid;
    logic [1:0]  cnt;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  cur = '0;
  st_t  act, m;
  st_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [31:0] o_pc, o_d1, o_d2, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [3:0]  o_funct;
  logic        o_rw, o_mr, o_mw, o_m2r, o_as, o_br, o_valid, pcw, ifw;
  logic [1:0]  o_aluop, o_cnt;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .reset(rst_n), .Hold(cur.hold), .Flush(cur.flush),
    .IF_ID_RS1(cur.rs1), .IF_ID_RS2(cur.rs2), .IF_ID_Rd(cur.rd),
    .IF_ID_UsesRS1(cur.u1), .IF_ID_UsesRS2(cur.u2), .IF_ID_PC(cur.pc),
    .RS1_Data(cur.d1), .RS2_Data(cur.d2), .Imm(cur.imm), .Funct(cur.funct),
    .Ctrl_RegWrite(cur.rw), .Ctrl_MemRead(cur.mr), .Ctrl_MemWrite(cur.mw),
    .Ctrl_MemtoReg(cur.m2r), .Ctrl_ALUSrc(cur.as), .Ctrl_Branch(cur.br),
    .Ctrl_ALUOp(cur.aluop),
    .ID_EX_PC(o_pc), .ID_EX_RS1_Data(o_d1), .ID_EX_RS2_Data(o_d2), .ID_EX_Imm(o_imm),
    .ID_EX_RS1(o_rs1), .ID_EX_RS2(o_rs2), .ID_EX_Rd(o_rd), .ID_EX_Funct(o_funct),
    .ID_EX_RegWrite(o_rw), .ID_EX_MemRead(o_mr), .ID_EX_MemWrite(o_mw),
    .ID_EX_MemtoReg(o_m2r), .ID_EX_ALUSrc(o_as), .ID_EX_Branch(o_br),
    .ID_EX_ALUOp(o_aluop), .ID_EX_Valid(o_valid),
    .PCWrite(pcw), .IF_ID_Write(ifw), .Bubble_Count(o_cnt)
  );

  assign act = '{pc: o_pc, d1: o_d1, d2: o_d2, imm: o_imm, rs1: o_rs1, rs2: o_rs2, rd: o_rd,
                 funct: o_funct, rw: o_rw, mr: o_mr, mw: o_mw, m2r: o_m2r, as: o_as,
                 br: o_br, aluop: o_aluop, valid: o_valid, cnt: o_cnt};

  task automatic check_state(input string name, input st_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  // Monitor: every rising edge with an outstanding prediction is compared.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check_state("edge_state", exp_q.pop_front());
  end

  // Drive one ID-stage cycle, check the stall outputs, predict the next edge.
  task automatic apply(input in_t x);
    bit stall;
    st_t n;
    @(negedge clk);
    cur = x;
    #1;
    // A dependent consumer must wait one cycle behind a real load to a nonzero register.
    stall = m.valid && m.mr && (m.rd != 0) &&
            ((x.u1 && x.rs1 == m.rd) || (x.u2 && x.rs2 == m.rd));
    check_bit("PCWrite", pcw, !x.hold && !(stall && !x.flush));
    check_bit("IF_ID_Write", ifw, !x.hold && !(stall && !x.flush));
    n = m;
    if (x.hold) begin
      n = m;
    end else if (x.flush) begin
      n = '0;
      n.cnt = m.cnt;
    end else if (stall) begin
      n = '0;
      n.cnt = (m.cnt == 2'd3) ? 2'd3 : m.cnt + 2'd1;
    end else begin
      n = '{pc: x.pc, d1: x.d1, d2: x.d2, imm: x.imm, rs1: x.rs1, rs2: x.rs2, rd: x.rd,
            funct: x.funct, rw: x.rw, mr: x.mr, mw: x.mw, m2r: x.m2r, as: x.as, br: x.br,
            aluop: x.aluop, valid: 1'b1, cnt: m.cnt};
    end
    exp_q.push_back(n);
    m = n;
  endtask

  function automatic in_t instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] rd, input logic mr);
    in_t x;
    x = '0;
    x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2; x.rd = rd; x.mr = mr;
    x.rw = 1'b1; x.m2r = mr; x.as = mr;
    x.pc = $urandom; x.d1 = $urandom; x.d2 = $urandom; x.imm = $urandom;
    x.funct = 4'($urandom); x.aluop = 2'($urandom);
    return x;
  endfunction

  task automatic mid_reset();
    @(negedge clk);
    cur.hold = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_reset", '0);
    check_bit("reset_PCWrite", pcw, 1'b1);
    m = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    in_t x;
    m = '0;
    #3;
    check_state("reset_state", '0);
    check_bit("reset_PCWrite", pcw, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // lw x5 then add x6,x5,x7: one stall, bubble, then add enters with RS1=5
    apply(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1));
    x = instr(5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b0);
    apply(x);
    apply(x);
    // lw x0 followed by a reader of x0: no stall
    apply(instr(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1));
    apply(instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b0));
    // load-use coinciding with flush
    apply(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1));
    x = instr(5'd0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b0);
    x.flush = 1'b1;
    apply(x);
    // hold three cycles over valid Rd=9 with flush pending, then release
    apply(instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0));
    x = instr(5'd9, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1);
    x.hold = 1'b1;
    x.flush = 1'b1;
    repeat (3) apply(x);
    x.hold = 1'b0;
    apply(x);
    // chained loads to x4 force repeated stalls so the 2-bit counter saturates
    x = instr(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
    repeat (11) apply(x);
    // reset with a valid load sitting in ID/EX
    apply(instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1));
    mid_reset();

    for (int i = 0; i < 400; i++) begin
      x = instr(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom));
      x.mw = 1'($urandom); x.br = 1'($urandom); x.rw = 1'($urandom);
      x.hold = ($urandom_range(0, 7) == 0);
      x.flush = ($urandom_range(0, 7) == 0);
      apply(x);
      if (i == 200) mid_reset();
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
